// File: rtl/roll_button_conditioner.sv
// roll_button_conditioner
// Turns the raw, bouncy roll push-button into a clean roll enable for the
// dice counter: synchroniser, debouncer, press detector and spin-burst FSM.
// Optional feature: define ROLL_HOLD_EN to keep roll asserted while the
// button is still held when the spin burst expires.

module roll_button_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SPIN_CYCLES     = 12
) (
   input  logic clk,
   input  logic reset,
   input  logic button_in,
   output logic roll,
   output logic rolling,
   output logic roll_done,
   output logic btn_level
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int SPIN_W = $clog2(SPIN_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      SPIN         = 2'd1,
      WAIT_RELEASE = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sync_q;
   logic [DB_W-1:0]        db_cnt;
   logic                   press;

   state_t                 state;
   state_t                 state_nx;
   logic [SPIN_W-1:0]      spin_cnt;
   logic [SPIN_W-1:0]      spin_cnt_nx;
   logic                   roll_nx;
   logic                   roll_done_nx;

   // Shift the asynchronous button through the synchroniser chain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], button_in};
      end
   end

   assign sync_q = sync_r[SYNC_STAGES-1];

   // Accept a level change only after DEBOUNCE_CYCLES consecutive differing
   // samples; a press pulse is registered on the accepted rising edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_cnt    <= '0;
         btn_level <= 1'b0;
         press     <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sync_q != btn_level) begin
            if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               btn_level <= ~btn_level;
               db_cnt    <= '0;
               press     <= ~btn_level;
            end else begin
               db_cnt <= db_cnt + DB_W'(1);
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   // FSM state, spin counter and the registered roll / roll_done outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         spin_cnt  <= '0;
         roll      <= 1'b0;
         roll_done <= 1'b0;
      end else begin
         state     <= state_nx;
         spin_cnt  <= spin_cnt_nx;
         roll      <= roll_nx;
         roll_done <= roll_done_nx;
      end
   end

   // Next-state logic: one accepted press in IDLE launches one spin burst.
   always_comb begin
      state_nx    = state;
      spin_cnt_nx = spin_cnt;
      case (state)
         IDLE: begin
            if (press) begin
               state_nx    = SPIN;
               spin_cnt_nx = SPIN_W'(SPIN_CYCLES);
            end
         end
         SPIN: begin
            if (spin_cnt == SPIN_W'(1)) begin
`ifdef ROLL_HOLD_EN
               // Counter parks at 1 while held, so the exit test repeats each cycle.
               if (!btn_level) begin
                  state_nx    = IDLE;
                  spin_cnt_nx = '0;
               end
`else
               state_nx    = btn_level ? WAIT_RELEASE : IDLE;
               spin_cnt_nx = '0;
`endif
            end else begin
               spin_cnt_nx = spin_cnt - SPIN_W'(1);
            end
         end
         WAIT_RELEASE: begin
            if (!btn_level) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx    = IDLE;
            spin_cnt_nx = '0;
         end
      endcase
   end

   // Output decode from the next state so roll and roll_done leave flops.
   always_comb begin
      roll_nx      = (state_nx == SPIN);
      roll_done_nx = (state == SPIN) && (state_nx != SPIN);
   end

   assign rolling = (state != IDLE);

endmodule

// File: tb/tb_roll_button_conditioner.sv
// tb_roll_button_conditioner
// Scoreboard bench: stimulus pushes expected output transitions (signal,
// value, cycle) into a queue; a negedge monitor pops one entry per observed
// transition and compares. Defaults SYNC_STAGES=2, DEBOUNCE_CYCLES=16,
// SPIN_CYCLES=12, so btn_level rises 17 edges after the first sampling edge.

module tb_roll_button_conditioner;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic button_in = 1'b0;
   logic roll;
   logic rolling;
   logic roll_done;
   logic btn_level;

   typedef struct {
      int   id;
      logic val;
      int   cyc;
   } exp_t;

   exp_t  exp_q[$];
   int    n_cmp = 0;
   int    n_fail = 0;
   int    cyc = 0;
   bit    mon_en = 1'b0;
   logic [3:0] cur;
   logic [3:0] prev;
   string names[4] = '{"btn_level", "roll", "rolling", "roll_done"};

   roll_button_conditioner #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(16),
      .SPIN_CYCLES    (12)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .button_in(button_in),
      .roll     (roll),
      .rolling  (rolling),
      .roll_done(roll_done),
      .btn_level(btn_level)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic push(input int id, input logic val, input int c);
      exp_t e;
      e.id  = id;
      e.val = val;
      e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic check_event(input int id, input logic v);
      exp_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL event: unexpected %s -> %0b at cycle %0d, required no change",
                  names[id], v, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.id != id || e.val !== v || e.cyc != cyc) begin
            n_fail++;
            $display("FAIL event: got %s -> %0b at cycle %0d, required %s -> %0b at cycle %0d",
                     names[id], v, cyc, names[e.id], e.val, e.cyc);
         end
      end
   endtask

   task automatic check_now(input string nm, input logic act, input logic expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %b, required %b", nm, act, expv);
      end
   endtask

   task automatic drain(input string nm);
      int k = 0;
      while (exp_q.size() != 0 && k < 400) begin
         @(negedge clk);
         #1;
         k++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s drain: %0d expected events still pending, required 0",
                  nm, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Monitor: every output transition seen at the falling edge is one event.
   always @(negedge clk) begin
      if (mon_en) begin
         cur = {roll_done, rolling, roll, btn_level};
         for (int i = 0; i < 4; i++) begin
            if (cur[i] !== prev[i]) check_event(i, cur[i]);
         end
         prev = cur;
      end
   end

   // Clean press held for hold_len sampled cycles (hold_len >= 13, so the
   // debounced level is still high when the burst expires).
   // E = first sampling edge of the press, R = first sampling edge of release.
   task automatic press(input int hold_len);
      int e;
      int r;
      @(negedge clk);
      button_in = 1'b1;
      e = cyc + 1;
      r = e + hold_len;
      push(0, 1'b1, e + 17);
      push(1, 1'b1, e + 18);
      push(2, 1'b1, e + 18);
`ifdef ROLL_HOLD_EN
      push(0, 1'b0, r + 17);
      push(1, 1'b0, r + 18);
      push(2, 1'b0, r + 18);
      push(3, 1'b1, r + 18);
      push(3, 1'b0, r + 19);
`else
      push(1, 1'b0, e + 30);
      push(3, 1'b1, e + 30);
      push(3, 1'b0, e + 31);
      push(0, 1'b0, r + 17);
      push(2, 1'b0, r + 18);
`endif
      repeat (hold_len) @(negedge clk);
      button_in = 1'b0;
   endtask

   initial begin
      int e;

      // Reset with button low: every output held at 0.
      repeat (5) @(negedge clk);
      check_now("reset btn_level", btn_level, 1'b0);
      check_now("reset roll", roll, 1'b0);
      check_now("reset rolling", rolling, 1'b0);
      check_now("reset roll_done", roll_done, 1'b0);
      reset = 1'b0;
      prev = {roll_done, rolling, roll, btn_level};
      mon_en = 1'b1;
      repeat (50) @(negedge clk);
      drain("idle");

      // Clean press held 40 cycles.
      press(40);
      drain("clean press");
      repeat (20) @(negedge clk);

      // Bounce: toggle every 5 cycles for 60 cycles, then hold high.
      for (int s = 0; s < 12; s++) begin
         button_in = (s % 2 == 0) ? 1'b1 : 1'b0;
         repeat (5) @(negedge clk);
      end
      press(40);
      drain("bounce");
      repeat (20) @(negedge clk);

      // Glitch: 10 cycles high never reaches the debounce threshold.
      @(negedge clk);
      button_in = 1'b1;
      repeat (10) @(negedge clk);
      button_in = 1'b0;
      repeat (40) @(negedge clk);
      drain("glitch");

      // Asynchronous reset during the 5th roll cycle, button already released.
      @(negedge clk);
      button_in = 1'b1;
      e = cyc + 1;
      push(0, 1'b1, e + 17);
      push(1, 1'b1, e + 18);
      push(2, 1'b1, e + 18);
      repeat (20) @(negedge clk);
      button_in = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b1;
      push(0, 1'b0, e + 23);
      push(1, 1'b0, e + 23);
      push(2, 1'b0, e + 23);
      #1;
      check_now("async reset roll", roll, 1'b0);
      check_now("async reset rolling", rolling, 1'b0);
      check_now("async reset roll_done", roll_done, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (50) @(negedge clk);
      drain("mid reset");

      // Long hold of 100 cycles.
      press(100);
      drain("hold 100");
      repeat (20) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
